// File: rtl/jam_pkg.sv
// jam_pkg: shared defaults and FSM state type for the job-assignment cost arbiter
package jam_pkg;
    localparam int IDXW_DEF      = 3;
    localparam int CW_DEF        = 7;
    localparam int MAX_BURST_DEF = 8;
    typedef enum logic {ARB, LOCK} state_t;
endpackage

// File: rtl/jam_rr_pick.sv
// jam_rr_pick: combinational round-robin picker, first set request at or above ptr with wrap
module jam_rr_pick #(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] idx,
    output logic          found
);
    logic [N-1:0] rot;
    logic [PW:0]  sum;
    always_comb begin
        rot = N'({req, req} >> ptr);
        sum = '0;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) sum = (PW+1)'(ptr) + (PW+1)'(i);
        idx   = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : PW'(sum);
        found = |req;
    end
endmodule

// File: rtl/jam_cost_arbiter.sv
// jam_cost_arbiter: burst-locked round-robin sharing of one cost table among NREQ engines
module jam_cost_arbiter
    import jam_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int IDXW      = IDXW_DEF,
    parameter int CW        = CW_DEF
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NREQ-1:0]      REQ,
    input  logic [NREQ*IDXW-1:0] REQ_W,
    input  logic [NREQ*IDXW-1:0] REQ_J,
    input  logic [NREQ-1:0]      REQ_LAST,
    output logic [NREQ-1:0]      GNT,
    output logic [IDXW-1:0]      W,
    output logic [IDXW-1:0]      J,
    input  logic [CW-1:0]        Cost,
    output logic [NREQ-1:0]      RSP_VALID,
    output logic [CW-1:0]        RSP_COST,
    output logic                 BUSY
);
    localparam int PW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_BURST) + 1;

    state_t          state;
    logic [PW-1:0]   rr_ptr, owner, pick;
    logic            found;
    logic [BW-1:0]   beat_cnt;
    logic [IDXW-1:0] w_sel, j_sel;
    logic            req_sel, last_sel, beat, done;

    jam_rr_pick #(.N(NREQ), .PW(PW)) u_pick (
        .req  (REQ),
        .ptr  (rr_ptr),
        .idx  (pick),
        .found(found)
    );

    always_comb begin
        w_sel    = '0;
        j_sel    = '0;
        req_sel  = 1'b0;
        last_sel = 1'b0;
        for (int k = 0; k < NREQ; k++)
            if (owner == PW'(k)) begin
                w_sel    = REQ_W[k*IDXW +: IDXW];
                j_sel    = REQ_J[k*IDXW +: IDXW];
                req_sel  = REQ[k];
                last_sel = REQ_LAST[k];
            end
    end

    assign BUSY = (state == LOCK);
    assign GNT  = BUSY ? NREQ'(1) << owner : '0;
    assign W    = BUSY ? w_sel : '0;
    assign J    = BUSY ? j_sel : '0;
    assign beat = BUSY && req_sel;
    assign done = beat && (last_sel || beat_cnt == BW'(MAX_BURST - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ARB;
            rr_ptr    <= '0;
            owner     <= '0;
            beat_cnt  <= '0;
            RSP_VALID <= '0;
            RSP_COST  <= '0;
        end else begin
            RSP_VALID <= beat ? GNT : '0;
            if (beat) RSP_COST <= Cost;
            if (state == ARB) begin
                if (found) begin
                    owner    <= pick;
                    beat_cnt <= '0;
                    state    <= LOCK;
                end
            end else if (beat) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (done) begin
                    state  <= ARB;
                    rr_ptr <= (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_jam_cost_arbiter.sv
// tb_jam_cost_arbiter: directed checks of burst locking, round-robin order, stalls and release
module tb_jam_cost_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0, rlast = '0, gnt, rsp_valid;
    logic [5:0]  rw = '0, rj = '0;
    logic [2:0]  w, j;
    logic [6:0]  cost, rsp_cost;
    logic        busy;
    logic [3:0]  reqb = '0, rlastb = '0, gntb, rspb_valid;
    logic [11:0] rwb = '0, rjb = '0;
    logic [2:0]  wb, jb;
    logic [6:0]  costb, rspb_cost;
    logic        busyb;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;
    assign cost  = {4'b0, w} + {4'b0, j};
    assign costb = {4'b0, wb} + {4'b0, jb};

    jam_cost_arbiter #(.NREQ(2), .MAX_BURST(8), .IDXW(3), .CW(7)) dut (
        .CLK(clk), .RST_N(rst_n), .REQ(req), .REQ_W(rw), .REQ_J(rj), .REQ_LAST(rlast),
        .GNT(gnt), .W(w), .J(j), .Cost(cost), .RSP_VALID(rsp_valid), .RSP_COST(rsp_cost),
        .BUSY(busy)
    );

    jam_cost_arbiter #(.NREQ(4), .MAX_BURST(8), .IDXW(3), .CW(7)) dut4 (
        .CLK(clk), .RST_N(rst_n), .REQ(reqb), .REQ_W(rwb), .REQ_J(rjb), .REQ_LAST(rlastb),
        .GNT(gntb), .W(wb), .J(jb), .Cost(costb), .RSP_VALID(rspb_valid), .RSP_COST(rspb_cost),
        .BUSY(busyb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // single engine, 8-beat burst ending on REQ_LAST
        req = 2'b01;
        @(negedge clk);
        chk("s_gnt", gnt, 2'b01);
        chk("s_busy", busy, 1);
        chk("s_rsp0", rsp_valid, 2'b00);
        for (int i = 0; i < 8; i++) begin
            rw = {3'd0, 3'(i)};
            rj = {3'd0, 3'(i)};
            rlast = (i == 7) ? 2'b01 : 2'b00;
            #1;
            chk("s_w", w, i);
            chk("s_j", j, i);
            @(negedge clk);
            chk("s_rspv", rsp_valid, 2'b01);
            chk("s_cost", rsp_cost, 2 * i);
            chk("s_busy_i", busy, i < 7);
        end
        req = '0;
        rlast = '0;
        @(negedge clk);
        chk("s_rsp_end", rsp_valid, 2'b00);
        chk("s_cost_hold", rsp_cost, 14);
        chk("s_gnt_end", gnt, 2'b00);
        // round-robin, both engines requesting continuously
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req = 2'b11;
        rw = {3'd5, 3'd2};
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                chk("rr_gnt", gnt, (b % 2) ? 2'b10 : 2'b01);
                chk("rr_rsp11", rsp_valid == 2'b11, 0);
                if (k == 0) chk("rr_w", w, (b % 2) ? 5 : 2);
                rlast = (k == 7) ? 2'b11 : 2'b00;
            end
            @(negedge clk);
            chk("rr_gap", gnt, 2'b00);
            chk("rr_gap_busy", busy, 0);
            rlast = '0;
        end
        // owner stall: engine 1 drops REQ while engine 0 waits
        req = 2'b10;
        @(negedge clk);
        chk("st_gnt", gnt, 2'b10);
        @(negedge clk);
        @(negedge clk);
        chk("st_rsp", rsp_valid, 2'b10);
        req = 2'b01;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("st_hold", gnt, 2'b10);
            chk("st_norsp", rsp_valid, 2'b00);
        end
        req = 2'b11;
        rlast = 2'b10;
        @(negedge clk);
        chk("st_last", rsp_valid, 2'b10);
        chk("st_rel", busy, 0);
        req = 2'b01;
        rlast = '0;
        @(negedge clk);
        chk("st_next", gnt, 2'b01);
        // forced release after MAX_BURST beats without REQ_LAST
        req = 2'b11;
        for (int k = 0; k < 8; k++) begin
            chk("fr_gnt", gnt, 2'b01);
            @(negedge clk);
        end
        chk("fr_busy", busy, 0);
        chk("fr_gap", gnt, 2'b00);
        @(negedge clk);
        chk("fr_next", gnt, 2'b10);
        // asynchronous reset in the middle of a burst
        rw = {3'd6, 3'd6};
        rj = {3'd3, 3'd3};
        @(negedge clk);
        chk("rs_pre_w", w, 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_gnt", gnt, 2'b00);
        chk("rs_rsp", rsp_valid, 2'b00);
        chk("rs_busy", busy, 0);
        chk("rs_w", w, 0);
        chk("rs_j", j, 0);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        // NREQ=4 pointer wrap
        reqb = 4'b0100;
        rlastb = 4'b0100;
        @(negedge clk);
        chk("n4_g2", gntb, 4'b0100);
        @(negedge clk);
        chk("n4_arb", gntb, 4'b0000);
        reqb = 4'b0101;
        rlastb = 4'b0101;
        @(negedge clk);
        chk("n4_wrap", gntb, 4'b0001);
        @(negedge clk);
        chk("n4_rsp", rspb_valid, 4'b0001);
        @(negedge clk);
        chk("n4_next", gntb, 4'b0100);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
